// File: rtl/hs_pkg.sv
// Shared types for the four-phase transmit adapter.
// Latency: none (types and constants only).
// Backpressure: n/a.
package hs_pkg;

  // Handshake sequencer states: wait for work, hold request, wait for ack release.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_tx_state_e;

  localparam int DATA_W_DEFAULT = 16;

endpackage

// File: rtl/hs_fifo.sv
// Small synchronous FIFO; the head word is visible combinationally on rdata.
// Latency: a word pushed at edge n is at the head (empty=0) after edge n.
// Backpressure: push is ignored while full (even with a same-cycle pop); pop is ignored while empty.
module hs_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer computation from the qualified push/pop strobes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hs_tx_adapter.sv
// Buffers valid/ready words and sends each across the CDC with a four-phase req/ack handshake.
// Latency: word accepted at edge n raises req_l after edge n+1; ack adds 0 cycles (2 with HS_TX_ACK_SYNC_EN).
// Backpressure: in_ready = !full; a full FIFO stalls upstream until the IDLE->REQ pop frees an entry.
// Optional macro HS_TX_ACK_SYNC_EN: insert a 2-flop synchronizer on ack_l.
module hs_tx_adapter
  import hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_l,
  input  logic              ack_l,
  output logic [DATA_W-1:0] data_l,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  hs_tx_state_e      state_q;
  logic              req_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_pop;
  logic              ack_s;

  assign in_ready = !fifo_full;
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef HS_TX_ACK_SYNC_EN
  logic [1:0] ack_sync_q;

  // Two-stage synchronizer: ack_l may come straight from the receiving domain.
  always_ff @(posedge clk) begin
    if (rst) ack_sync_q <= 2'b00;
    else     ack_sync_q <= {ack_sync_q[0], ack_l};
  end

  assign ack_s = ack_sync_q[1];
`else
  assign ack_s = ack_l;
`endif

  // Handshake sequencer with registered req/data/busy/count outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // An ack seen here is stale or spurious and is deliberately ignored.
          if (!fifo_empty) begin
            data_q  <= fifo_rdata;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          // data_l stays put until the receiver drops ack.
          if (!ack_s) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_l    = req_q;
  assign data_l   = data_q;
  assign busy     = busy_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_hs_tx_adapter.sv
// Self-checking bench for hs_tx_adapter: vector table, directed corner cases, random traffic vs queue model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours HS_TX_ACK_SYNC_EN for the expected ack latency.
module tb_hs_tx_adapter;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
`ifdef HS_TX_ACK_SYNC_EN
  localparam int ACK_LAT = 2;
`else
  localparam int ACK_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          req_l;
  logic          ack_l = 1'b0;
  logic [DW-1:0] data_l;
  logic          busy;
  logic [CW-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  hs_tx_adapter #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req_l    (req_l),
    .ack_l    (ack_l),
    .data_l   (data_l),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one full cycle, ending on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full four-phase cycle driven by the bench, ack following req after 3 cycles.
  task automatic do_handshake(input logic [DW-1:0] exp, input string tag);
    int n;
    n = 0;
    while (!req_l && n < 20) begin tick(); n++; end
    check({tag, " req rise"}, req_l, 1);
    check({tag, " data"}, data_l, exp);
    repeat (3) tick();
    ack_l = 1'b1;
    n = 0;
    while (req_l && n < 20) begin
      check({tag, " data held"}, data_l, exp);
      tick();
      n++;
    end
    check({tag, " req fall"}, req_l, 0);
    check({tag, " data release"}, data_l, exp);
    ack_l = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check({tag, " idle"}, busy, 0);
  endtask

  // Random-phase model state: words held in the FIFO, completed handshakes.
  logic [DW-1:0] mq[$];
  int            mcnt = 0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] cur_word = '0;
  logic          pend_acc = 1'b0;
  logic [DW-1:0] pend_dat = '0;
  int            ack_dly = 0;

  task automatic rnd_step(input bit allow_push);
    logic exp_rdy;
    if (req_l && !prev_req) begin
      if (mq.size() == 0) begin
        check("rnd req with empty model", 1, 0);
      end else begin
        cur_word = mq.pop_front();
        check("rnd head data", data_l, cur_word);
      end
    end else if (req_l || ack_l) begin
      check("rnd data stable", data_l, cur_word);
    end
    if (!req_l && prev_req) mcnt++;
    if (pend_acc) mq.push_back(pend_dat);
    check("rnd xfer_cnt", xfer_cnt, mcnt & 32'hFFFF);
    exp_rdy = (mq.size() < DEPTH);
    check("rnd in_ready", in_ready, exp_rdy);
    prev_req = req_l;
    // Receiver: ack follows req after a random 0..3 cycle delay, both edges.
    if (ack_l != req_l) begin
      if (ack_dly == 0) begin
        ack_l   = req_l;
        ack_dly = $urandom_range(0, 3);
      end else begin
        ack_dly--;
      end
    end
    in_valid = allow_push && ($urandom_range(0, 2) != 0);
    in_data  = DW'($urandom);
    pend_acc = in_valid && exp_rdy;
    pend_dat = in_data;
    tick();
  endtask

  typedef struct {
    logic          rst;
    logic          v;
    logic [DW-1:0] d;
    logic          ack;
    logic          e_req;
    logic [DW-1:0] e_data;
    logic          e_rdy;
    logic          e_busy;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Reset, then park 0x00AA in REQ and fill the FIFO with 1..4; 5 must bounce.
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h00AA, 1'b1, 1'b1, 16'd0};
    tbl[4] = '{1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h00AA, 1'b1, 1'b1, 16'd0};
    tbl[5] = '{1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 16'h00AA, 1'b1, 1'b1, 16'd0};
    tbl[6] = '{1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b1, 16'd0};
    tbl[7] = '{1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b1, 16'd0};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b1, 16'd0};

    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rst      = tbl[i].rst;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      ack_l    = tbl[i].ack;
      tick();
      check($sformatf("vec%0d req_l", i),    req_l,    tbl[i].e_req);
      check($sformatf("vec%0d data_l", i),   data_l,   tbl[i].e_data);
      check($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d busy", i),     busy,     tbl[i].e_busy);
      check($sformatf("vec%0d xfer_cnt", i), xfer_cnt, tbl[i].e_cnt);
    end

    // Drain: words emerge in order, the rejected 0x0005 never appears.
    do_handshake(16'h00AA, "fill w0");
    do_handshake(16'h0001, "fill w1");
    do_handshake(16'h0002, "fill w2");
    do_handshake(16'h0003, "fill w3");
    do_handshake(16'h0004, "fill w4");
    repeat (4) tick();
    check("fill no extra req", req_l, 0);
    check("fill count", xfer_cnt, 5);
    check("fill ready", in_ready, 1);

    // Single word with exact cycle timing.
    in_valid = 1'b1;
    in_data  = 16'h4444;
    tick();
    in_valid = 1'b0;
    check("sw req after push edge", req_l, 0);
    tick();
    check("sw req after pop edge", req_l, 1);
    check("sw data", data_l, 16'h4444);
    repeat (3) tick();
    ack_l = 1'b1;
    for (int k = 0; k < ACK_LAT; k++) begin
      tick();
      check("sw req held during ack sync", req_l, 1);
    end
    tick();
    check("sw req fall", req_l, 0);
    check("sw count", xfer_cnt, 6);
    check("sw data in release", data_l, 16'h4444);
    ack_l = 1'b0;
    for (int k = 0; k < ACK_LAT; k++) begin
      tick();
      check("sw busy held during ack sync", busy, 1);
    end
    check("sw busy before release edge", busy, 1);
    tick();
    check("sw busy after release", busy, 0);

    // Spurious ack in IDLE with nothing queued.
    ack_l = 1'b1;
    repeat (3) tick();
    check("spur req", req_l, 0);
    ack_l = 1'b0;
    repeat (ACK_LAT + 2) tick();
    check("spur req after", req_l, 0);
    check("spur busy", busy, 0);
    check("spur count", xfer_cnt, 6);

    // Reset in the middle of REQ with a second word still queued.
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    tick();
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    check("rst pre req", req_l, 1);
    check("rst pre data", data_l, 16'hBEEF);
    rst = 1'b1;
    tick();
    check("rst req drop", req_l, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    check("rst count", xfer_cnt, 0);
    check("rst data", data_l, 0);
    rst = 1'b0;
    repeat (6) tick();
    check("rst fifo discarded", req_l, 0);
    check("rst stays idle", busy, 0);

    // Random traffic against the queue model, then drain.
    mcnt     = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 800; c++) rnd_step(1'b1);
    for (int c = 0; c < 400 && (mq.size() != 0 || pend_acc || busy || req_l || ack_l); c++)
      rnd_step(1'b0);
    check("rnd drained model", mq.size(), 0);
    check("rnd drained busy", busy, 0);
    check("rnd final count", xfer_cnt, mcnt & 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
